// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
//============================================================================
// Module   : pipe_hazard_ctrl_if
// Purpose  : Bundle between the decode stage and the hazard / flow-control
//            unit. It carries the decode fields and the PC-write strobe
//            toward the unit, and the pipe controls, forwarding selects and
//            performance counters back.
// Modports : master - decode-stage side (drives decode fields, br_taken)
//            slave  - hazard unit side (drives issue/stall/bubble/flush,
//                     fwd_src1/2, stall_cnt/flush_cnt)
// Revision : 1.0 - initial release
//============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int STAGES   = 3,
  parameter int SEL_BITS = 4,
  parameter int CNT_W    = 16
);
  localparam int FWD_W = $clog2(STAGES + 1);

  // decode-side fields
  logic                dec_valid;
  logic [SEL_BITS-1:0] dec_rs1;
  logic [SEL_BITS-1:0] dec_rs2;
  logic                dec_rs1_used;
  logic                dec_rs2_used;
  logic                dec_wr_en;
  logic [SEL_BITS-1:0] dec_wr_reg;
  logic                dec_fwd_ok;
  logic                br_taken;

  // controls and status from the hazard unit
  logic                issue;
  logic                stall_fd;
  logic                bubble_ex;
  logic                flush_fd;
  logic [FWD_W-1:0]    fwd_src1;
  logic [FWD_W-1:0]    fwd_src2;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    flush_cnt;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_wr_en, dec_wr_reg, dec_fwd_ok, br_taken,
    input  issue, stall_fd, bubble_ex, flush_fd, fwd_src1, fwd_src2,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_wr_en, dec_wr_reg, dec_fwd_ok, br_taken,
    output issue, stall_fd, bubble_ex, flush_fd, fwd_src1, fwd_src2,
           stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard and flow-control unit beside the decode stage of the
//            vector ASIP pipeline. A shift-register scoreboard follows the
//            destination register of every instruction from decode to the
//            register-file write. Read-after-write hazards hold fetch/decode
//            and inject a bubble into execute; a taken PC write flushes the
//            fetch-decode pipe and squashes the younger in-flight slots.
//            Stall cycles and flush events are counted with saturation.
// Ports    : clk - clock
//            rst - synchronous reset, active low
//            hz  - pipe_hazard_ctrl_if.slave (decode fields in; issue,
//                  stall_fd, bubble_ex, flush_fd, fwd_src1/2, stall_cnt,
//                  flush_cnt out)
// Options  : PIPE_FWD_EN - when defined, matches on forwardable results in
//            slots 1..STAGES-1 do not stall and fwd_src1/2 select the
//            youngest matching slot; otherwise every match stalls and the
//            forwarding selects are tied to 0.
// Revision : 1.0 - initial release
//============================================================================
module pipe_hazard_ctrl #(
  parameter int STAGES   = 3,
  parameter int SEL_BITS = 4,
  parameter int BR_STAGE = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int               FWD_W   = $clog2(STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Scoreboard, one entry per in-flight slot; slot 0 = EX.
  logic [STAGES-1:0]   ent_valid;
  logic [STAGES-1:0]   ent_wr;
  logic [STAGES-1:0]   ent_fwd;
  logic [SEL_BITS-1:0] ent_reg [STAGES];

  logic [STAGES-1:0] match1;
  logic [STAGES-1:0] match2;
  logic [STAGES-1:0] block1;
  logic [STAGES-1:0] block2;

  logic             hazard;
  logic             issue;
  logic             stall_fd;
  logic             flush_fd;
  logic [FWD_W-1:0] fwd_src1;
  logic [FWD_W-1:0] fwd_src2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             unused_fwd;

  //--------------------------------------------------------------------------
  // Per-slot source matching. Every slot up to and including the one that
  // writes the regfile is still a hazard: the write lands on the edge that
  // ends the last slot, too late for a read in the same cycle.
  //--------------------------------------------------------------------------
  for (genvar i = 0; i < STAGES; i++) begin : g_match
    assign match1[i] = ent_valid[i] && ent_wr[i] && hz.dec_rs1_used &&
                       (ent_reg[i] == hz.dec_rs1);
    assign match2[i] = ent_valid[i] && ent_wr[i] && hz.dec_rs2_used &&
                       (ent_reg[i] == hz.dec_rs2);
`ifdef PIPE_FWD_EN
    if (i == 0) begin : g_ex
      // EX result is produced at the end of this cycle: never forwardable.
      assign block1[i] = match1[i];
      assign block2[i] = match2[i];
    end else begin : g_late
      assign block1[i] = match1[i] && !ent_fwd[i];
      assign block2[i] = match2[i] && !ent_fwd[i];
    end
`else
    assign block1[i] = match1[i];
    assign block2[i] = match2[i];
`endif
  end

  assign hazard = hz.dec_valid && (|block1 || |block2);

  //--------------------------------------------------------------------------
  // Pipe controls. rst is active low, so every control is qualified with rst
  // to hold the reset output values while reset is applied. A taken PC write
  // wins over a hazard: the stalled instruction is being squashed anyway.
  //--------------------------------------------------------------------------
  assign flush_fd = rst && hz.br_taken;
  assign stall_fd = rst && hazard && !hz.br_taken;
  assign issue    = rst && hz.dec_valid && !hazard && !hz.br_taken;

  //--------------------------------------------------------------------------
  // Forwarding selects: youngest (lowest slot) match wins because it holds
  // the most recent value of that register.
  //--------------------------------------------------------------------------
`ifdef PIPE_FWD_EN
  always_comb begin
    fwd_src1 = '0;
    fwd_src2 = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (match1[i]) fwd_src1 = FWD_W'(i + 1);
      if (match2[i]) fwd_src2 = FWD_W'(i + 1);
    end
    if (!rst) begin
      fwd_src1 = '0;
      fwd_src2 = '0;
    end
  end
  // Slot 0 never consults its forwardable flag.
  assign unused_fwd = ent_fwd[0];
`else
  assign fwd_src1   = '0;
  assign fwd_src2   = '0;
  assign unused_fwd = ^ent_fwd;
`endif

  //--------------------------------------------------------------------------
  // Scoreboard shift and performance counters.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_valid <= '0;
      ent_wr    <= '0;
      ent_fwd   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ent_valid[0] <= issue;
      ent_wr[0]    <= issue && hz.dec_wr_en;
      ent_fwd[0]   <= hz.dec_fwd_ok;
      for (int i = 1; i < STAGES; i++) begin
        // Slots 0..BR_STAGE after the edge are younger than the branch,
        // which itself moves on to BR_STAGE+1 untouched. The flush is
        // applied even if the branch slot was empty.
        ent_valid[i] <= ent_valid[i-1] && !(hz.br_taken && (i <= BR_STAGE));
        ent_wr[i]    <= ent_wr[i-1];
        ent_fwd[i]   <= ent_fwd[i-1];
      end
      if (stall_fd && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (hz.br_taken && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  // Register selects need no reset: they are only looked at when valid.
  always_ff @(posedge clk) begin
    ent_reg[0] <= hz.dec_wr_reg;
    for (int i = 1; i < STAGES; i++) begin
      ent_reg[i] <= ent_reg[i-1];
    end
  end

  assign hz.issue     = issue;
  assign hz.stall_fd  = stall_fd;
  assign hz.bubble_ex = !issue;
  assign hz.flush_fd  = flush_fd;
  assign hz.fwd_src1  = fwd_src1;
  assign hz.fwd_src2  = fwd_src2;
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. A behavioural model
//            keeps a queue of in-flight writers tagged with their age in
//            cycles since issue; hazards, flushes, forwarding selects and
//            counters are derived from that queue. A second instance with
//            4-bit counters shares the stimulus to exercise saturation.
// Revision : 1.0 - initial release
//============================================================================
module tb_pipe_hazard_ctrl;
  localparam int STAGES   = 3;
  localparam int SEL_BITS = 4;
  localparam int BR_STAGE = 1;
  localparam int CNT_W    = 16;
  localparam int SAT_W    = 4;
  localparam int FWD_W    = $clog2(STAGES + 1);
`ifdef PIPE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.STAGES(STAGES), .SEL_BITS(SEL_BITS), .CNT_W(CNT_W)) bus ();
  pipe_hazard_ctrl_if #(.STAGES(STAGES), .SEL_BITS(SEL_BITS), .CNT_W(SAT_W)) bus_sat ();

  assign bus_sat.dec_valid    = bus.dec_valid;
  assign bus_sat.dec_rs1      = bus.dec_rs1;
  assign bus_sat.dec_rs2      = bus.dec_rs2;
  assign bus_sat.dec_rs1_used = bus.dec_rs1_used;
  assign bus_sat.dec_rs2_used = bus.dec_rs2_used;
  assign bus_sat.dec_wr_en    = bus.dec_wr_en;
  assign bus_sat.dec_wr_reg   = bus.dec_wr_reg;
  assign bus_sat.dec_fwd_ok   = bus.dec_fwd_ok;
  assign bus_sat.br_taken     = bus.br_taken;

  pipe_hazard_ctrl #(.STAGES(STAGES), .SEL_BITS(SEL_BITS), .BR_STAGE(BR_STAGE), .CNT_W(CNT_W))
    dut (.clk(clk), .rst(rst), .hz(bus));
  pipe_hazard_ctrl #(.STAGES(STAGES), .SEL_BITS(SEL_BITS), .BR_STAGE(BR_STAGE), .CNT_W(SAT_W))
    dut_sat (.clk(clk), .rst(rst), .hz(bus_sat));

  //--------------------------------------------------------------------------
  // Reference model
  //--------------------------------------------------------------------------
  typedef struct {
    logic [SEL_BITS-1:0] rd;
    bit                  fwd;
    int                  age;   // cycles since issue == slot index
  } rec_t;

  rec_t q[$];
  int   m_stall = 0;
  int   m_flush = 0;
  bit   e_issue, e_stall, e_flush, e_bubble;
  logic [FWD_W-1:0] e_src1, e_src2;
  int   errors = 0;
  int   checks = 0;

  function automatic int sat(int v, int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit blocks(rec_t r);
    return (r.age == 0) || !r.fwd || !FWD_EN;
  endfunction

  function automatic void model_eval();
    bit h = 1'b0;
    int y1 = STAGES;
    int y2 = STAGES;
    foreach (q[k]) begin
      if (bus.dec_rs1_used && q[k].rd == bus.dec_rs1) begin
        if (q[k].age < y1) y1 = q[k].age;
        if (blocks(q[k])) h = 1'b1;
      end
      if (bus.dec_rs2_used && q[k].rd == bus.dec_rs2) begin
        if (q[k].age < y2) y2 = q[k].age;
        if (blocks(q[k])) h = 1'b1;
      end
    end
    h        = h && bus.dec_valid;
    e_flush  = rst && bus.br_taken;
    e_stall  = rst && h && !bus.br_taken;
    e_issue  = rst && bus.dec_valid && !h && !bus.br_taken;
    e_bubble = !e_issue;
    e_src1   = '0;
    e_src2   = '0;
    if (FWD_EN && rst && y1 < STAGES) e_src1 = FWD_W'(y1 + 1);
    if (FWD_EN && rst && y2 < STAGES) e_src2 = FWD_W'(y2 + 1);
  endfunction

  // One clock edge for DUT and model together.
  task automatic tick();
    rec_t nq[$];
    model_eval();
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      foreach (q[k]) begin
        if (!(bus.br_taken && q[k].age < BR_STAGE) && (q[k].age + 1 < STAGES))
          nq.push_back('{rd: q[k].rd, fwd: q[k].fwd, age: q[k].age + 1});
      end
      if (e_issue && bus.dec_wr_en)
        nq.push_back('{rd: bus.dec_wr_reg, fwd: bus.dec_fwd_ok, age: 0});
      q = nq;
      if (e_stall) m_stall++;
      if (e_flush) m_flush++;
    end
    #1;
  endtask

  task automatic drive(bit v, int rs1, bit u1, int rs2, bit u2,
                       bit we, int rd, bit fok, bit br);
    bus.dec_valid    = v;
    bus.dec_rs1      = SEL_BITS'(rs1);
    bus.dec_rs1_used = u1;
    bus.dec_rs2      = SEL_BITS'(rs2);
    bus.dec_rs2_used = u2;
    bus.dec_wr_en    = we;
    bus.dec_wr_reg   = SEL_BITS'(rd);
    bus.dec_fwd_ok   = fok;
    bus.br_taken     = br;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  //--------------------------------------------------------------------------
  // Scenarios
  //--------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    drive(1, 1, 1, 2, 1, 1, 3, 0, 0);
    for (int c = 0; c < 2; c++) begin
      checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL reset_issue c=%0d got=%b exp=0", c, bus.issue); end
      checks++; if (bus.bubble_ex !== 1'b1) begin errors++; $display("FAIL reset_bubble c=%0d got=%b exp=1", c, bus.bubble_ex); end
      checks++; if (bus.stall_fd !== 1'b0) begin errors++; $display("FAIL reset_stall c=%0d got=%b exp=0", c, bus.stall_fd); end
      tick();
    end
    checks++; if (bus.stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt); end
    checks++; if (bus.flush_cnt !== '0) begin errors++; $display("FAIL reset_flush_cnt got=%0d exp=0", bus.flush_cnt); end
    checks++; if (bus.fwd_src1 !== '0) begin errors++; $display("FAIL reset_fwd1 got=%0d exp=0", bus.fwd_src1); end
    drive(1, 1, 1, 2, 1, 1, 3, 0, 1);
    checks++; if (bus.flush_fd !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", bus.flush_fd); end
    rst = 1'b1;
    drive(1, 1, 1, 2, 1, 1, 3, 0, 0);
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL reset_release_issue got=%b exp=1", bus.issue); end
  endtask

  task automatic test_raw_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL raw_writer_issue got=%b exp=1", bus.issue); end
    tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < STAGES; c++) begin
      checks++; if (bus.stall_fd !== 1'b1) begin errors++; $display("FAIL raw_stall c=%0d got=%b exp=1", c, bus.stall_fd); end
      checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL raw_hold c=%0d got=%b exp=0", c, bus.issue); end
      tick();
    end
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL raw_release got=%b exp=1", bus.issue); end
    checks++; if (bus.stall_fd !== 1'b0) begin errors++; $display("FAIL raw_release_stall got=%b exp=0", bus.stall_fd); end
    checks++; if (bus.stall_cnt !== CNT_W'(3)) begin errors++; $display("FAIL raw_stall_cnt got=%0d exp=3", bus.stall_cnt); end
    tick();
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
    tick();
    drive(1, 4, 1, 3, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.issue !== 1'b1 || bus.stall_fd !== 1'b0) begin errors++; $display("FAIL nofalse c=%0d got issue=%b stall=%b exp issue=1 stall=0", c, bus.issue, bus.stall_fd); end
      tick();
    end
    checks++; if (bus.stall_cnt !== '0) begin errors++; $display("FAIL nofalse_cnt got=%0d exp=0", bus.stall_cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);  // A: the branch, writes r1
    tick();
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0);  // B: younger, writes r2
    tick();
    // A in slot 1, B in slot 0; decode reads r2, so a hazard coincides
    drive(1, 2, 1, 0, 0, 0, 0, 0, 1);
    checks++; if (bus.flush_fd !== 1'b1) begin errors++; $display("FAIL br_flush got=%b exp=1", bus.flush_fd); end
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL br_issue got=%b exp=0", bus.issue); end
    checks++; if (bus.stall_fd !== 1'b0) begin errors++; $display("FAIL br_stall_prio got=%b exp=0", bus.stall_fd); end
    checks++; if (bus.bubble_ex !== 1'b1) begin errors++; $display("FAIL br_bubble got=%b exp=1", bus.bubble_ex); end
    tick();
    drive(1, 2, 1, 0, 0, 0, 0, 0, 0);  // B squashed: no hazard on r2
    checks++; if (bus.stall_fd !== 1'b0 || bus.issue !== 1'b1) begin errors++; $display("FAIL br_squashed got stall=%b issue=%b exp stall=0 issue=1", bus.stall_fd, bus.issue); end
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0);  // A survives in slot 2
    checks++; if (bus.stall_fd !== 1'b1) begin errors++; $display("FAIL br_survivor got=%b exp=1", bus.stall_fd); end
    checks++; if (bus.flush_cnt !== CNT_W'(1)) begin errors++; $display("FAIL br_flush_cnt got=%0d exp=1", bus.flush_cnt); end
    checks++; if (bus.flush_fd !== 1'b0) begin errors++; $display("FAIL br_flush_drop got=%b exp=0", bus.flush_fd); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_forwarding();
    // forwardable writer, one bubble, then the reader
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 5, 1, 5, 1, 0, 0, 0, 0);
    checks++; if (bus.stall_fd !== !FWD_EN) begin errors++; $display("FAIL fwd_stall got=%b exp=%b", bus.stall_fd, !FWD_EN); end
    checks++; if (bus.fwd_src1 !== (FWD_EN ? FWD_W'(2) : FWD_W'(0))) begin errors++; $display("FAIL fwd_src1 got=%0d exp=%0d", bus.fwd_src1, FWD_EN ? 2 : 0); end
    checks++; if (bus.fwd_src2 !== (FWD_EN ? FWD_W'(2) : FWD_W'(0))) begin errors++; $display("FAIL fwd_src2 got=%0d exp=%0d", bus.fwd_src2, FWD_EN ? 2 : 0); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // non-forwardable writer must stall until it retires
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      checks++; if (bus.stall_fd !== 1'b1) begin errors++; $display("FAIL nofwd_stall c=%0d got=%b exp=1", c, bus.stall_fd); end
      checks++; if (bus.fwd_src1 !== (FWD_EN ? FWD_W'(c + 2) : FWD_W'(0))) begin errors++; $display("FAIL nofwd_src c=%0d got=%0d exp=%0d", c, bus.fwd_src1, FWD_EN ? c + 2 : 0); end
      tick();
    end
    checks++; if (bus.issue !== 1'b1 || bus.fwd_src1 !== '0) begin errors++; $display("FAIL nofwd_release got issue=%b src=%0d exp issue=1 src=0", bus.issue, bus.fwd_src1); end
    tick();
  endtask

  task automatic test_saturation();
    int c;
    do_reset();
    // each instruction reads and writes r3, so it waits behind its predecessor
    drive(1, 3, 1, 0, 0, 1, 3, 0, 0);
    for (c = 0; c < 200 && m_stall < 20; c++) tick();
    checks++; if (m_stall != 20) begin errors++; $display("FAIL sat_budget got=%0d exp=20 stall cycles", m_stall); end
    checks++; if (bus.stall_cnt !== CNT_W'(20)) begin errors++; $display("FAIL sat_stall_wide got=%0d exp=20", bus.stall_cnt); end
    checks++; if (bus_sat.stall_cnt !== SAT_W'(15)) begin errors++; $display("FAIL sat_stall_narrow got=%0d exp=15", bus_sat.stall_cnt); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (20) tick();
    checks++; if (bus.flush_cnt !== CNT_W'(20)) begin errors++; $display("FAIL sat_flush_wide got=%0d exp=20", bus.flush_cnt); end
    checks++; if (bus_sat.flush_cnt !== SAT_W'(15)) begin errors++; $display("FAIL sat_flush_narrow got=%0d exp=15", bus_sat.flush_cnt); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 5), $urandom_range(0, 1),
            $urandom_range(0, 5), $urandom_range(0, 1),
            $urandom_range(0, 2) != 0, $urandom_range(0, 5),
            $urandom_range(0, 1), $urandom_range(0, 9) == 0);
      model_eval();
      checks++; if (bus.issue !== e_issue) begin errors++; $display("FAIL rnd_issue c=%0d got=%b exp=%b", c, bus.issue, e_issue); end
      checks++; if (bus.stall_fd !== e_stall) begin errors++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, bus.stall_fd, e_stall); end
      checks++; if (bus.bubble_ex !== e_bubble) begin errors++; $display("FAIL rnd_bubble c=%0d got=%b exp=%b", c, bus.bubble_ex, e_bubble); end
      checks++; if (bus.flush_fd !== e_flush) begin errors++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, bus.flush_fd, e_flush); end
      checks++; if (bus.fwd_src1 !== e_src1) begin errors++; $display("FAIL rnd_fwd1 c=%0d got=%0d exp=%0d", c, bus.fwd_src1, e_src1); end
      checks++; if (bus.fwd_src2 !== e_src2) begin errors++; $display("FAIL rnd_fwd2 c=%0d got=%0d exp=%0d", c, bus.fwd_src2, e_src2); end
      checks++; if (bus.stall_cnt !== CNT_W'(sat(m_stall, CNT_W))) begin errors++; $display("FAIL rnd_stall_cnt c=%0d got=%0d exp=%0d", c, bus.stall_cnt, sat(m_stall, CNT_W)); end
      checks++; if (bus.flush_cnt !== CNT_W'(sat(m_flush, CNT_W))) begin errors++; $display("FAIL rnd_flush_cnt c=%0d got=%0d exp=%0d", c, bus.flush_cnt, sat(m_flush, CNT_W)); end
      checks++; if (bus_sat.stall_cnt !== SAT_W'(sat(m_stall, SAT_W))) begin errors++; $display("FAIL rnd_sat_stall c=%0d got=%0d exp=%0d", c, bus_sat.stall_cnt, sat(m_stall, SAT_W)); end
      checks++; if (bus_sat.flush_cnt !== SAT_W'(sat(m_flush, SAT_W))) begin errors++; $display("FAIL rnd_sat_flush c=%0d got=%0d exp=%0d", c, bus_sat.flush_cnt, sat(m_flush, SAT_W)); end
      tick();
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_no_false_hazard();
    test_branch();
    test_forwarding();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
